fetch_unit: RTL

- Instruction fetch stage of the 5-stage RISC-V core. Sits in front of decode.
- Owns the PC and issues word requests to the instruction cache.
- Produces the fetch/decode pipeline register (fd_pc, fd_instr) and the icache_stall signal that decode consumes.
- Consumes decode's load_stall, branch_stall, branch_en and branch_PC. Holds, flushes or redirects the stream accordingly.
- Includes a one-entry hold buffer, so an instruction returned while decode is stalled is not lost or re-requested.

---
 rtl/fetch_unit.sv | 109 ++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues single-word icache requests and
// drives the fetch/decode register, with a one-entry hold buffer for decode stalls.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] BUBBLE   = 32'h0000_0013,
  parameter int          CNT_W    = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             dcache_stall,
  input  logic             load_stall,
  input  logic             branch_stall,
  input  logic             branch_en,
  input  logic [31:0]      branch_PC,
  output logic             ic_req,
  output logic [31:0]      ic_addr,
  input  logic             ic_ack,
  input  logic [31:0]      ic_data,
  output logic             icache_stall,
  output logic [31:0]      fd_pc,
  output logic [31:0]      fd_instr,
  output logic [CNT_W-1:0] fetch_count,
  output logic [CNT_W-1:0] icache_wait_cycles
);

  typedef enum logic {FETCH, HOLD} state_t;

  state_t             state_reg, state_next;
  logic [31:0]        pc_reg, pc_next;
  logic [31:0]        buf_reg, buf_next;
  logic [31:0]        fd_pc_reg, fd_pc_next;
  logic [31:0]        fd_instr_reg, fd_instr_next;
  logic [CNT_W-1:0]   fetch_count_reg, fetch_count_next;
  logic [CNT_W-1:0]   wait_count_reg, wait_count_next;

  logic               src_valid;
  logic [31:0]        src;
  logic               commit;
  logic               unused_branch_bits;

  // Branch targets are forced to word alignment, so the low bits are dropped.
  assign unused_branch_bits = ^branch_PC[1:0];

  assign ic_req       = (state_reg == FETCH);
  assign ic_addr      = {pc_reg[31:2], 2'b00};
  assign icache_stall = ic_req & ~ic_ack;

  assign src_valid = (state_reg == HOLD) | ic_ack;
  assign src       = (state_reg == HOLD) ? buf_reg : ic_data;

  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    buf_next      = buf_reg;
    fd_pc_next    = fd_pc_reg;
    fd_instr_next = fd_instr_reg;
    commit        = 1'b0;

    // With no instruction available everything holds, whatever decode asks for.
    if (src_valid) begin
      if (dcache_stall || (!branch_en && (load_stall || branch_stall))) begin
        if (state_reg == FETCH) begin
          buf_next   = ic_data;
          state_next = HOLD;
        end
      end else if (branch_en) begin
        fd_instr_next = BUBBLE;
        fd_pc_next    = 32'h0;
        pc_next       = {branch_PC[31:2], 2'b00};
        state_next    = FETCH;
      end else begin
        fd_instr_next = src;
        fd_pc_next    = pc_reg;
        pc_next       = pc_reg + 32'd4;
        state_next    = FETCH;
        commit        = 1'b1;
      end
    end

    fetch_count_next = fetch_count_reg + {{(CNT_W-1){1'b0}}, commit};
    wait_count_next  = wait_count_reg + {{(CNT_W-1){1'b0}}, icache_stall};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg       <= FETCH;
      pc_reg          <= RESET_PC;
      buf_reg         <= 32'h0;
      fd_pc_reg       <= 32'h0;
      fd_instr_reg    <= BUBBLE;
      fetch_count_reg <= '0;
      wait_count_reg  <= '0;
    end else begin
      state_reg       <= state_next;
      pc_reg          <= pc_next;
      buf_reg         <= buf_next;
      fd_pc_reg       <= fd_pc_next;
      fd_instr_reg    <= fd_instr_next;
      fetch_count_reg <= fetch_count_next;
      wait_count_reg  <= wait_count_next;
    end
  end

  assign fd_pc              = fd_pc_reg;
  assign fd_instr           = fd_instr_reg;
  assign fetch_count        = fetch_count_reg;
  assign icache_wait_cycles = wait_count_reg;

endmodule
